// File: rtl/sky130_as_sc_hs_pkg.sv
// sky130_as_sc_hs_pkg: shared limits for the sky130_as_sc_hs register bank cells
package sky130_as_sc_hs_pkg;
  localparam int SC_MAX_WIDTH = 64;
  localparam int SC_MAX_STAGES = 8;
endpackage

// File: rtl/sky130_as_sc_hs__icg_1.sv
// sky130_as_sc_hs__icg_1: latch-based integrated clock gate, enable captured while CLK is low
module sky130_as_sc_hs__icg_1
  import sky130_as_sc_hs_pkg::*;
(
  input  logic CLK,
  input  logic GATE,
  input  logic VPWR,
  input  logic VGND,
  input  logic VPB,
  input  logic VNB,
  output logic GCLK
);
  logic r_en;
  logic w_unused_pwr;
  always_latch begin
    if (!CLK) r_en = GATE;
  end
  assign GCLK = CLK & r_en;
  assign w_unused_pwr = ^{VPWR, VGND, VPB, VNB};
endmodule

// File: rtl/sky130_as_sc_hs__sdfrbank.sv
// sky130_as_sc_hs__sdfrbank: multi-stage scan register bank with data enable,
// async reset and a gated clock; the scan chain threads every stage LSB to MSB.
module sky130_as_sc_hs__sdfrbank
  import sky130_as_sc_hs_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STAGES = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] D,
  input  logic             DE,
  input  logic             SCE,
  input  logic             SCD,
  input  logic             VPWR,
  input  logic             VGND,
  input  logic             VPB,
  input  logic             VNB,
  output logic [WIDTH-1:0] Q,
  output logic             SCQ
);
  if (WIDTH < 1 || WIDTH > SC_MAX_WIDTH) begin : g_bad_width
    $fatal(1, "sky130_as_sc_hs__sdfrbank: WIDTH %0d out of range", WIDTH);
  end
  if (STAGES < 1 || STAGES > SC_MAX_STAGES) begin : g_bad_stages
    $fatal(1, "sky130_as_sc_hs__sdfrbank: STAGES %0d out of range", STAGES);
  end
  logic [WIDTH-1:0] r_stg [STAGES];
  logic [STAGES-1:0] w_sin;
  logic w_gclk;
  sky130_as_sc_hs__icg_1 u_icg (
    .CLK (CLK),
    .GATE(SCE | DE),
    .VPWR(VPWR),
    .VGND(VGND),
    .VPB (VPB),
    .VNB (VNB),
    .GCLK(w_gclk)
  );
  // Scan input of each stage is the MSB of the stage before it.
  always_comb begin
    w_sin[0] = SCD;
    for (int k = 1; k < STAGES; k++) w_sin[k] = r_stg[k-1][WIDTH-1];
  end
  // Gated clock only ticks when SCE|DE, so the empty else is the hold case.
  always_ff @(posedge w_gclk or posedge RESET) begin
    if (RESET) begin
      for (int k = 0; k < STAGES; k++) r_stg[k] <= RESET_VAL;
    end else if (SCE) begin
      for (int k = 0; k < STAGES; k++) r_stg[k] <= (r_stg[k] << 1) | WIDTH'(w_sin[k]);
    end else if (DE) begin
      r_stg[0] <= D;
      for (int k = 1; k < STAGES; k++) r_stg[k] <= r_stg[k-1];
    end
  end
  assign Q = r_stg[STAGES-1];
  assign SCQ = r_stg[STAGES-1][WIDTH-1];
endmodule
